// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache arbiter/sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        FILL,
        WRITE,
        RESP
    } arb_state_t;

    localparam int PORT_IF = 0;
    localparam int PORT_LS = 1;
    localparam int PERF_W  = 32;

    // One-hot response vector for a latched port index.
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin arbiter; the port not granted last wins a conflict.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant with its own state.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Lone requester always wins; on conflict favour the other port.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one cache lookup port between fetch and LSU, sequences refill and write-through; optional CACHE_ARB_PERF_EN counters.
// Latency: read hit 2 cycles after accept, miss ack+2, write ack+1; one transaction in flight.
// Backpressure: req_ready only in IDLE to the arbitration winner; rsp_valid cannot be stalled.
module cache_arbiter
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [ADDR_W-1:0]     cache_addr,
    output logic                  cache_lookup,
    input  logic                  cache_hit,
    input  logic [DATA_W-1:0]     cache_rdata,
    output logic                  cache_fill,
    output logic [DATA_W-1:0]     cache_fill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef CACHE_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0]     perf_hits,
    output logic [PERF_W-1:0]     perf_misses,
    output logic [PERF_W-1:0]     perf_stalls
`endif
);

    arb_state_t        state_q;
    logic              port_q;
    logic              we_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              cache_lookup_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [1:0]        grant;
    logic              win_ls;
    logic              lookup_wr_hit;
    logic              unused_we_if;

    // Fetch port is read-only; its write-enable bit is intentionally dropped.
    assign unused_we_if = req_we[PORT_IF];

    rr_arbiter_2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign req_ready = (state_q == IDLE) ? grant : 2'b00;
    assign win_ls    = grant[PORT_LS];

    // Write hits update the line in place during the lookup cycle itself.
    assign lookup_wr_hit   = (state_q == LOOKUP) && we_q && cache_hit;
    assign cache_fill      = lookup_wr_hit || (state_q == FILL);
    assign cache_fill_data = (state_q == FILL) ? data_q :
                             lookup_wr_hit     ? wdata_q : '0;

    assign cache_addr   = addr_q;
    assign cache_lookup = cache_lookup_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

    // Transaction sequencer with registered strobes; pulses default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            port_q         <= 1'b0;
            we_q           <= 1'b0;
            last_grant_q   <= 1'b1;
            addr_q         <= '0;
            wdata_q        <= '0;
            data_q         <= '0;
            rsp_valid_q    <= 2'b00;
            rsp_rdata_q    <= '0;
            cache_lookup_q <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
        end else begin
            cache_lookup_q <= 1'b0;
            rsp_valid_q    <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (|req_ready) begin
                        port_q         <= win_ls;
                        we_q           <= win_ls & req_we[PORT_LS];
                        addr_q         <= win_ls ? req_addr[2*ADDR_W-1:ADDR_W]
                                                 : req_addr[ADDR_W-1:0];
                        wdata_q        <= win_ls ? req_wdata[2*DATA_W-1:DATA_W]
                                                 : req_wdata[DATA_W-1:0];
                        last_grant_q   <= win_ls;
                        cache_lookup_q <= 1'b1;
                        state_q        <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (we_q) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= wdata_q;
                        state_q     <= WRITE;
                    end else if (cache_hit) begin
                        data_q      <= cache_rdata;
                        rsp_valid_q <= port_onehot(port_q);
                        rsp_rdata_q <= cache_rdata;
                        state_q     <= RESP;
                    end else begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= addr_q;
                        state_q     <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        data_q    <= mem_rdata;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    rsp_valid_q <= port_onehot(port_q);
                    rsp_rdata_q <= data_q;
                    state_q     <= RESP;
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        rsp_valid_q <= port_onehot(port_q);
                        rsp_rdata_q <= '0;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_ARB_PERF_EN
    logic [PERF_W-1:0] perf_hits_q;
    logic [PERF_W-1:0] perf_misses_q;
    logic [PERF_W-1:0] perf_stalls_q;
    logic              lookup_rd;
    logic              stall;

    assign lookup_rd = (state_q == LOOKUP) && !we_q;
    assign stall     = |(req_valid & ~req_ready);

    // Saturating event counters for read hits/misses and blocked requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (lookup_rd && cache_hit && (perf_hits_q != '1))
                perf_hits_q <= perf_hits_q + 1'b1;
            if (lookup_rd && !cache_hit && (perf_misses_q != '1))
                perf_misses_q <= perf_misses_q + 1'b1;
            if (stall && (perf_stalls_q != '1))
                perf_stalls_q <= perf_stalls_q + 1'b1;
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: reset, hit/miss/write paths, arbitration, mid-transaction reset.
// Latency: expectations counted in cycles from the accept cycle T (T+1 = LOOKUP).
// Backpressure: the bench sinks every rsp_valid pulse and plays the memory responder.
module tb_cache_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [31:0] cache_addr;
    logic        cache_lookup;
    logic        cache_hit;
    logic [31:0] cache_rdata;
    logic        cache_fill;
    logic [31:0] cache_fill_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef CACHE_ARB_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
    logic [31:0] perf_stalls;
`endif

    cache_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .cache_addr      (cache_addr),
        .cache_lookup    (cache_lookup),
        .cache_hit       (cache_hit),
        .cache_rdata     (cache_rdata),
        .cache_fill      (cache_fill),
        .cache_fill_data (cache_fill_data),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata)
`ifdef CACHE_ARB_PERF_EN
        ,
        .perf_hits       (perf_hits),
        .perf_misses     (perf_misses),
        .perf_stalls     (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observations from the most recent txn() call; cycle numbers count from accept T.
    logic [31:0] r_acc, r_rsp, r_rdata, r_lat, r_ack_cyc, r_mreq;
    logic [31:0] r_mem_we, r_mem_addr, r_mem_wdata;
    logic [31:0] r_fills, r_fill_dat, r_fill_addr, r_fill_cyc, r_lookup_cyc;

    // One request on a single port; memory acks on the ack_dly-th cycle mem_req is seen high.
    task automatic txn(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic hit, input logic [31:0] hdata,
                       input int ack_dly, input logic [31:0] mdata);
        int c;
        logic done;
        r_acc = 0; r_rsp = 0; r_rdata = 0; r_lat = 0; r_ack_cyc = 0; r_mreq = 0;
        r_mem_we = 0; r_mem_addr = 0; r_mem_wdata = 0;
        r_fills = 0; r_fill_dat = 0; r_fill_addr = 0; r_fill_cyc = 0; r_lookup_cyc = 0;
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_valid[port] = 1'b1;
        req_we[port]    = we;
        req_addr[port*32 +: 32]  = addr;
        req_wdata[port*32 +: 32] = wdata;
        cache_hit   = hit;
        cache_rdata = hdata;
        for (int i = 0; i < 20 && r_acc == 0; i++) begin
            @(negedge clk);
            if (req_ready[port]) r_acc = 1;
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        c = 1;
        done = 1'b0;
        while (!done && c < 60) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                r_rsp = 32'(rsp_valid); r_rdata = rsp_rdata; r_lat = c; done = 1'b1;
            end
            if (cache_lookup) r_lookup_cyc = c;
            if (cache_fill) begin
                r_fills++; r_fill_dat = cache_fill_data; r_fill_addr = cache_addr; r_fill_cyc = c;
            end
            if (mem_req) begin
                r_mreq++;
                r_mem_we = 32'(mem_we); r_mem_addr = mem_addr; r_mem_wdata = mem_wdata;
                if (r_mreq == ack_dly) begin
                    mem_ack = 1'b1; mem_rdata = mdata; r_ack_cyc = c;
                end
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            c++;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        mem_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [31:0] grants [4];
    int n_grants, n_rsp, n_pulse, n_mreq;
    logic seen;

    initial begin
        rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        cache_hit = 0; cache_rdata = 0; mem_ack = 0; mem_rdata = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready",    32'(req_ready), 32'h0);
        check("rst_rsp_valid",    32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata",    rsp_rdata, 32'h0);
        check("rst_cache_lookup", 32'(cache_lookup), 32'h0);
        check("rst_cache_fill",   32'(cache_fill), 32'h0);
        check("rst_fill_data",    cache_fill_data, 32'h0);
        check("rst_cache_addr",   cache_addr, 32'h0);
        check("rst_mem_req",      32'(mem_req), 32'h0);
        check("rst_mem_we",       32'(mem_we), 32'h0);
        check("rst_mem_addr",     mem_addr, 32'h0);
        check("rst_mem_wdata",    mem_wdata, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Both ports valid continuously: accepts every 3 cycles, alternating from port 0
        req_valid = 2'b11; req_we = 2'b00; cache_hit = 1'b1; cache_rdata = 32'h0000_0077;
        n_grants = 0; n_rsp = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                if (n_grants < 4) grants[n_grants] = 32'(req_ready);
                n_grants++;
            end
            if (rsp_valid != 2'b00) n_rsp++;
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        check("arb_grant_count", n_grants, 4);
        check("arb_grant0", grants[0], 32'h1);
        check("arb_grant1", grants[1], 32'h2);
        check("arb_grant2", grants[2], 32'h1);
        check("arb_grant3", grants[3], 32'h2);
        check("arb_rsp_count", n_rsp, 4);

        // Port 0 read hit at 0x10
        txn(0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1, 32'h0);
        check("hit_accept", r_acc, 1);
        check("hit_lookup_cyc", r_lookup_cyc, 1);
        check("hit_rsp", r_rsp, 32'h1);
        check("hit_lat", r_lat, 2);
        check("hit_rdata", r_rdata, 32'hDEADBEEF);
        check("hit_no_mem", r_mreq, 0);
        check("hit_no_fill", r_fills, 0);
        @(negedge clk);
        check("hit_rsp_one_cycle", 32'(rsp_valid), 32'h0);

        // Port 0 write-enable is ignored: still a read hit
        txn(0, 1'b1, 32'h14, 32'h1111, 1'b1, 32'hCAFEF00D, 1, 32'h0);
        check("if_we_rsp", r_rsp, 32'h1);
        check("if_we_rdata", r_rdata, 32'hCAFEF00D);
        check("if_we_no_mem", r_mreq, 0);
        check("if_we_no_fill", r_fills, 0);

        // Port 1 read miss at 0x24, memory acks on its 5th request cycle (cycle 6)
        txn(1, 1'b0, 32'h24, 32'h0, 1'b0, 32'hBAD0BAD0, 5, 32'h1234);
        check("miss_ack_cyc", r_ack_cyc, 6);
        check("miss_mem_we", r_mem_we, 0);
        check("miss_mem_addr", r_mem_addr, 32'h24);
        check("miss_fills", r_fills, 1);
        check("miss_fill_dat", r_fill_dat, 32'h1234);
        check("miss_fill_addr", r_fill_addr, 32'h24);
        check("miss_fill_cyc", r_fill_cyc, 7);
        check("miss_rsp", r_rsp, 32'h2);
        check("miss_lat", r_lat, 8);
        check("miss_rdata", r_rdata, 32'h1234);

        // Port 1 write hit at 0x8: update in LOOKUP, write-through, ack on 3rd cycle (cycle 4)
        txn(1, 1'b1, 32'h8, 32'hA5A5, 1'b1, 32'hFFFF_FFFF, 3, 32'h9999);
        check("wh_fills", r_fills, 1);
        check("wh_fill_cyc", r_fill_cyc, 1);
        check("wh_fill_dat", r_fill_dat, 32'hA5A5);
        check("wh_fill_addr", r_fill_addr, 32'h8);
        check("wh_mreq_cycles", r_mreq, 3);
        check("wh_mem_we", r_mem_we, 1);
        check("wh_mem_addr", r_mem_addr, 32'h8);
        check("wh_mem_wdata", r_mem_wdata, 32'hA5A5);
        check("wh_rsp", r_rsp, 32'h2);
        check("wh_lat", r_lat, 5);
        check("wh_rdata", r_rdata, 32'h0);

        // Port 1 write miss, ack in first WRITE cycle: no allocate
        txn(1, 1'b1, 32'h8, 32'h5A5A, 1'b0, 32'h0, 1, 32'h0);
        check("wm_no_fill", r_fills, 0);
        check("wm_ack_cyc", r_ack_cyc, 2);
        check("wm_mem_wdata", r_mem_wdata, 32'h5A5A);
        check("wm_rsp", r_rsp, 32'h2);
        check("wm_lat", r_lat, 3);

        // Reset during a port 0 refill: everything drops, response lost, port 0 wins next conflict
        @(posedge clk); #1;
        req_valid = 2'b01; req_we = 2'b00; req_addr[31:0] = 32'h40; cache_hit = 1'b0;
        @(negedge clk);
        check("rr_accept", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
        end
        check("rr_refill_entered", 32'(seen), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rr_mem_req_drop", 32'(mem_req), 32'h0);
        check("rr_rsp_none", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        n_pulse = 0; n_mreq = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) n_pulse++;
            if (mem_req) n_mreq++;
        end
        check("rr_no_late_rsp", n_pulse, 0);
        check("rr_no_mem_req", n_mreq, 0);
        req_valid = 2'b11; cache_hit = 1'b1;
        #1;
        check("rr_post_conflict", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (3) @(posedge clk);

        // Stray mem_ack in IDLE is ignored
        #1 mem_ack = 1'b1; mem_rdata = 32'hFFFF;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_rsp", 32'(rsp_valid), 32'h0);
        check("stray_ack_mem_req", 32'(mem_req), 32'h0);

`ifdef CACHE_ARB_PERF_EN
        do_reset();
        @(negedge clk);
        check("perf_rst_hits", perf_hits, 0);
        check("perf_rst_stalls", perf_stalls, 0);
        for (int i = 0; i < 3; i++) txn(0, 1'b0, 32'h100, 0, 1'b1, 32'h1, 1, 0);
        for (int i = 0; i < 2; i++) txn(0, 1'b0, 32'h200, 0, 1'b0, 32'h0, 2, 32'h2);
        @(negedge clk);
        check("perf_hits", perf_hits, 3);
        check("perf_misses", perf_misses, 2);
        check("perf_stalls_none", perf_stalls, 0);
        // One conflicting cycle: the loser stalls exactly once
        @(posedge clk); #1 req_valid = 2'b11; cache_hit = 1'b1;
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("perf_stalls_one", perf_stalls, 1);
        check("perf_hits_after", perf_hits, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
